// File: rtl/rvv_wb_collector_pkg.sv
// Shared types and helpers for the vector write-back collector.
// Holds the FSM state encoding, SEW codes and element-geometry functions.
package rvv_wb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } wb_state_e;

    localparam logic [2:0]  SEW8         = 3'd0;
    localparam logic [2:0]  SEW16        = 3'd1;
    localparam logic [2:0]  SEW32        = 3'd2;
    localparam logic [2:0]  SEW64        = 3'd3;
    localparam logic [10:0] ELEM_CNT_MAX = 11'd2047;

    // Codes above SEW64 are illegal and are handled as 64-bit elements.
    function automatic logic [6:0] sew_bits(input logic [2:0] vsew);
        logic [6:0] bits_s;
        case (vsew)
            SEW8:    bits_s = 7'd8;
            SEW16:   bits_s = 7'd16;
            SEW32:   bits_s = 7'd32;
            SEW64:   bits_s = 7'd64;
            default: bits_s = 7'd64;
        endcase
        return bits_s;
    endfunction

    function automatic logic [10:0] max_elems(input int vlen, input logic [2:0] vsew);
        return 11'(vlen / int'(sew_bits(vsew)));
    endfunction

endpackage

// File: rtl/rvv_wb_collector_lane_merge.sv
// Per-lane element placement: turns one (index, data) beat into a positioned
// write mask and data vector, and classifies the index against vl and VLEN/SEW.
module rvv_wb_lane_merge
    import rvv_wb_pkg::*;
#(
    parameter int VLEN = 128
) (
    input  logic [9:0]      index,
    input  logic [63:0]     data,
    input  logic [2:0]      sew_q,
    input  logic [10:0]     vl_q,
    input  logic            valid,
    output logic [VLEN-1:0] wr_mask,
    output logic [VLEN-1:0] wr_data,
    output logic            in_range,
    output logic            out_of_bounds
);

    logic [10:0] max_s;
    logic [10:0] limit_s;
    logic [10:0] index_s;
    logic [16:0] shamt_s;
    logic [63:0] ones_s;

    // Element classification and bit placement within the destination vector
    always_comb begin
        max_s   = max_elems(VLEN, sew_q);
        limit_s = (vl_q < max_s) ? vl_q : max_s;
        index_s = {1'b0, index};
        shamt_s = 17'(index) * 17'(sew_bits(sew_q));
        case (sew_q)
            SEW8:    ones_s = 64'h0000_0000_0000_00FF;
            SEW16:   ones_s = 64'h0000_0000_0000_FFFF;
            SEW32:   ones_s = 64'h0000_0000_FFFF_FFFF;
            default: ones_s = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        in_range      = valid && (index_s < limit_s);
        out_of_bounds = valid && (index_s >= max_s);
        if (in_range) begin
            wr_mask = VLEN'(ones_s) << shamt_s;
            wr_data = VLEN'(data & ones_s) << shamt_s;
        end else begin
            wr_mask = {VLEN{1'b0}};
            wr_data = {VLEN{1'b0}};
        end
    end

endmodule

// File: rtl/rvv_wb_collector.sv
// Vector write-back collector: merges lane results into old vd and hands the
// vector to the register file. Optional element masking via RVV_WB_MASK_EN.
module rvv_wb_collector
    import rvv_wb_pkg::*;
#(
    parameter int VLEN     = 128,
    parameter int NB_LANES = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [2:0]                   vsew,
    input  logic [10:0]                  vl,
    input  logic [VLEN-1:0]              old_vd,
`ifdef RVV_WB_MASK_EN
    input  logic                         vm,
    input  logic [VLEN-1:0]              v0,
`endif
    input  logic [(1<<NB_LANES)-1:0]     lane_valid,
    input  logic [64*(1<<NB_LANES)-1:0]  lane_data,
    input  logic [10*(1<<NB_LANES)-1:0]  lane_index,
    input  logic                         alu_done,
    input  logic                         wb_ready,
    output logic                         wb_valid,
    output logic [VLEN-1:0]              wb_data,
    output logic                         busy,
    output logic [10:0]                  elem_cnt,
    output logic                         err
);

    localparam int L = 1 << NB_LANES;

    wb_state_e       state_r, state_nxt_s;
    logic [VLEN-1:0] buf_r, wb_data_r, merged_s;
    logic [2:0]      sew_r;
    logic [10:0]     vl_r, elem_cnt_r, cnt_nxt_s;
    logic            wb_valid_r, busy_r, err_r, collect_s;
    logic [L-1:0]    lane_in_s, lane_oob_s, lane_ok_s, lane_wr_s;
    logic [VLEN-1:0] lane_mask_s  [L];
    logic [VLEN-1:0] lane_pdata_s [L];
    logic [3:0]      wr_cnt_s;
    logic [11:0]     cnt_sum_s;

    assign collect_s = (state_r == COLLECT);

    genvar k;
    generate
        for (k = 0; k < L; k++) begin : g_lane
            rvv_wb_lane_merge #(.VLEN(VLEN)) u_merge (
                .index         (lane_index[10*k +: 10]),
                .data          (lane_data[64*k +: 64]),
                .sew_q         (sew_r),
                .vl_q          (vl_r),
                .valid         (lane_valid[k] && collect_s),
                .wr_mask       (lane_mask_s[k]),
                .wr_data       (lane_pdata_s[k]),
                .in_range      (lane_in_s[k]),
                .out_of_bounds (lane_oob_s[k])
            );
        end
    endgenerate

`ifdef RVV_WB_MASK_EN
    logic            vm_r;
    logic [VLEN-1:0] v0_r, v0_sh_s;

    // Mask operands are captured with the instruction
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vm_r <= 1'b1;
            v0_r <= {VLEN{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            vm_r <= vm;
            v0_r <= v0;
        end else begin
            vm_r <= vm_r;
            v0_r <= v0_r;
        end
    end

    // Per-lane mask bit looked up by element index
    always_comb begin
        lane_ok_s = {L{1'b0}};
        v0_sh_s   = v0_r;
        for (int i = 0; i < L; i++) begin
            v0_sh_s      = v0_r >> lane_index[10*i +: 10];
            lane_ok_s[i] = vm_r | v0_sh_s[0];
        end
    end
`else
    // Without masking every in-range element is written
    always_comb begin
        lane_ok_s = {L{1'b1}};
    end
`endif

    assign lane_wr_s = lane_in_s & lane_ok_s;

    // Merge lanes in ascending order so the highest lane wins on a shared index
    always_comb begin
        merged_s = buf_r;
        wr_cnt_s = 4'd0;
        for (int i = 0; i < L; i++) begin
            if (lane_wr_s[i]) begin
                merged_s = (merged_s & ~lane_mask_s[i]) | lane_pdata_s[i];
                wr_cnt_s = wr_cnt_s + 4'd1;
            end else begin
                merged_s = merged_s;
            end
        end
        cnt_sum_s = {1'b0, elem_cnt_r} + {8'd0, wr_cnt_s};
        cnt_nxt_s = (cnt_sum_s > 12'd2047) ? ELEM_CNT_MAX : cnt_sum_s[10:0];
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (start)    state_nxt_s = COLLECT; else state_nxt_s = IDLE;
            COLLECT: if (alu_done) state_nxt_s = HOLD;    else state_nxt_s = COLLECT;
            HOLD:    if (wb_ready) state_nxt_s = IDLE;    else state_nxt_s = HOLD;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, buffer and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= IDLE;
            buf_r      <= {VLEN{1'b0}};
            wb_data_r  <= {VLEN{1'b0}};
            sew_r      <= SEW8;
            vl_r       <= 11'd0;
            elem_cnt_r <= 11'd0;
            wb_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wb_valid_r <= (state_nxt_s == HOLD);
            busy_r     <= (state_nxt_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        buf_r      <= old_vd;
                        sew_r      <= (vsew > SEW64) ? SEW64 : vsew;
                        vl_r       <= vl;
                        elem_cnt_r <= 11'd0;
                        err_r      <= (vsew > SEW64);
                    end else begin
                        buf_r      <= buf_r;
                    end
                end
                COLLECT: begin
                    buf_r      <= merged_s;
                    elem_cnt_r <= cnt_nxt_s;
                    err_r      <= err_r | (|lane_oob_s);
                    if (alu_done) begin
                        wb_data_r <= merged_s;
                    end else begin
                        wb_data_r <= wb_data_r;
                    end
                end
                default: begin
                    buf_r <= buf_r;
                end
            endcase
        end
    end

    assign wb_valid = wb_valid_r;
    assign wb_data  = wb_data_r;
    assign busy     = busy_r;
    assign elem_cnt = elem_cnt_r;
    assign err      = err_r;

endmodule

// File: tb/tb_rvv_wb_collector.sv
// Scoreboard bench for rvv_wb_collector (VLEN=128, two lanes): directed cases
// plus randomized instructions checked against an element-level reference model.
module tb_rvv_wb_collector;

    localparam int VLEN     = 128;
    localparam int NB_LANES = 1;
    localparam int L        = 2;

    logic              clk = 1'b0;
    logic              resetn, start, alu_done, wb_ready, vm;
    logic [2:0]        vsew;
    logic [10:0]       vl;
    logic [VLEN-1:0]   old_vd, v0;
    logic [L-1:0]      lane_valid;
    logic [64*L-1:0]   lane_data;
    logic [10*L-1:0]   lane_index;
    logic              wb_valid, busy, err;
    logic [VLEN-1:0]   wb_data;
    logic [10:0]       elem_cnt;

    typedef struct {
        logic [127:0] data;
        logic [10:0]  cnt;
        logic         err;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [1:0]   bq_valid[$];
    logic [127:0] bq_data[$];
    logic [19:0]  bq_idx[$];
    int           checks   = 0;
    int           failures = 0;

    rvv_wb_collector #(.VLEN(VLEN), .NB_LANES(NB_LANES)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .vsew       (vsew),
        .vl         (vl),
        .old_vd     (old_vd),
`ifdef RVV_WB_MASK_EN
        .vm         (vm),
        .v0         (v0),
`endif
        .lane_valid (lane_valid),
        .lane_data  (lane_data),
        .lane_index (lane_index),
        .alu_done   (alu_done),
        .wb_ready   (wb_ready),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .busy       (busy),
        .elem_cnt   (elem_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted write-back is compared with the oldest expectation
    always @(negedge clk) begin
        if (resetn && wb_valid && wb_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_wb", 128'd1, 128'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_wb_data", wb_data, mon_e.data);
                check("sb_elem_cnt", 128'(elem_cnt), 128'(mon_e.cnt));
                check("sb_err", 128'(err), 128'(mon_e.err));
            end
        end
    end

    task automatic push_beat(input logic [1:0] v, input logic [9:0] i0, input logic [63:0] d0,
                             input logic [9:0] i1, input logic [63:0] d1);
        bq_valid.push_back(v);
        bq_idx.push_back({i1, i0});
        bq_data.push_back({d1, d0});
    endtask

    function automatic bit mask_ok(input int idx);
`ifdef RVV_WB_MASK_EN
        return (vm == 1'b1) || (v0[idx] == 1'b1);
`else
        return (idx >= 0);
`endif
    endfunction

    // Issue one instruction from the beat queue; expected result goes to the scoreboard
    task automatic run_instr(input logic [2:0] vs, input logic [10:0] vlv, input logic [127:0] old,
                             input int hold, input bit pulse_start, output exp_t e);
        int sew, maxe, nb, idx;
        logic [1:0]   v;
        logic [127:0] d;
        logic [19:0]  ix;
        sew    = (vs > 3'd3) ? 64 : (8 << vs);
        maxe   = VLEN / sew;
        e.data = old;
        e.cnt  = 11'd0;
        e.err  = (vs > 3'd3);
        if (bq_valid.size() == 0) push_beat(2'b00, 10'd0, 64'd0, 10'd0, 64'd0);
        nb = bq_valid.size();
        @(posedge clk); #1;
        start = 1'b1; vsew = vs; vl = vlv; old_vd = old;
        @(posedge clk); #1;
        start  = 1'b0;
        old_vd = {$urandom, $urandom, $urandom, $urandom};
        for (int b = 0; b < nb; b++) begin
            v  = bq_valid.pop_front();
            d  = bq_data.pop_front();
            ix = bq_idx.pop_front();
            lane_valid = v; lane_data = d; lane_index = ix;
            alu_done   = (b == nb - 1);
            for (int k = 0; k < L; k++) begin
                if (v[k]) begin
                    idx = int'(ix[10*k +: 10]);
                    if (idx >= maxe) begin
                        e.err = 1'b1;
                    end else if (idx < int'(vlv) && mask_ok(idx)) begin
                        for (int bb = 0; bb < sew; bb++) e.data[idx*sew + bb] = d[64*k + bb];
                        e.cnt = e.cnt + 11'd1;
                    end
                end
            end
            @(negedge clk);
            if (b == 0) begin
                check("collect_busy", 128'(busy), 128'd1);
                check("collect_cnt_start", 128'(elem_cnt), 128'd0);
            end
            if (b == nb - 1) check("valid_before_done", 128'(wb_valid), 128'd0);
            @(posedge clk); #1;
        end
        sb_q.push_back(e);
        lane_valid = 2'b00; alu_done = 1'b0;
        @(negedge clk);
        check("valid_latency", 128'(wb_valid), 128'd1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            start = (pulse_start && h == 1);
            @(negedge clk);
            check("hold_valid", 128'(wb_valid), 128'd1);
            check("hold_data", wb_data, e.data);
        end
        @(posedge clk); #1;
        start = 1'b0; wb_ready = 1'b1;
        @(posedge clk); #1;
        wb_ready = 1'b0;
        @(negedge clk);
        check("idle_valid", 128'(wb_valid), 128'd0);
        check("idle_busy", 128'(busy), 128'd0);
        check("idle_data_held", wb_data, e.data);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   sew, maxe, nb;
        resetn = 1'b0; start = 1'b0; alu_done = 1'b0; wb_ready = 1'b0;
        vsew = 3'd0; vl = 11'd0; old_vd = 128'd0; vm = 1'b1; v0 = 128'd0;
        lane_valid = 2'b00; lane_data = 128'd0; lane_index = 20'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", 128'(wb_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_elem_cnt", 128'(elem_cnt), 128'd0);
        check("rst_err", 128'(err), 128'd0);
        check("rst_wb_data", wb_data, 128'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // alu_done and lane beats in IDLE are ignored
        alu_done = 1'b1; lane_valid = 2'b11;
        @(posedge clk); #1;
        alu_done = 1'b0; lane_valid = 2'b00;
        @(negedge clk);
        check("idle_done_ignored", 128'(wb_valid), 128'd0);
        check("idle_busy_low", 128'(busy), 128'd0);

        // SEW=8, two lanes, index pairs, data = index
        for (int p = 0; p < 8; p++)
            push_beat(2'b11, 10'(2*p), 64'(2*p), 10'(2*p+1), 64'(2*p+1));
        run_instr(3'd0, 11'd16, {16{8'hFF}}, 0, 1'b0, e);
        check("sew8_bytes", wb_data, 128'h0F0E0D0C0B0A09080706050403020100);

        // SEW=32, vl=3 leaves word3 undisturbed
        push_beat(2'b11, 10'd0, 64'h11111111, 10'd1, 64'h22222222);
        push_beat(2'b01, 10'd2, 64'h33333333, 10'd0, 64'd0);
        run_instr(3'd2, 11'd3, {4{32'hAAAAAAAA}}, 1, 1'b0, e);
        check("sew32_words", wb_data, 128'hAAAAAAAA_33333333_22222222_11111111);
        check("sew32_err", 128'(err), 128'd0);

        // SEW=64 out-of-bounds index, shared index, long hold with ignored start
        push_beat(2'b01, 10'd2, 64'hDEAD, 10'd0, 64'd0);
        push_beat(2'b11, 10'd0, 64'h1, 10'd0, 64'h2);
        run_instr(3'd3, 11'd2, {4{32'h5A5A5A5A}}, 5, 1'b1, e);
        check("sew64_upper_kept", wb_data, {64'h5A5A5A5A5A5A5A5A, 64'h2});
        check("sew64_err", 128'(err), 128'd1);

        // Illegal vsew behaves as SEW=64 and flags err
        push_beat(2'b01, 10'd1, 64'h123456789ABCDEF0, 10'd0, 64'd0);
        run_instr(3'd6, 11'd2, 128'h0, 2, 1'b0, e);
        check("bad_vsew_data", wb_data, {64'h123456789ABCDEF0, 64'h0});
        check("bad_vsew_err", 128'(err), 128'd1);

        // vl=0 writes nothing
        push_beat(2'b11, 10'd0, 64'hFF, 10'd1, 64'hEE);
        run_instr(3'd0, 11'd0, 128'hCAFEF00D, 0, 1'b0, e);
        check("vl0_data", wb_data, 128'hCAFEF00D);

`ifdef RVV_WB_MASK_EN
        vm = 1'b0; v0 = 128'h5;
        push_beat(2'b11, 10'd0, 64'hEE, 10'd1, 64'hEE);
        push_beat(2'b11, 10'd2, 64'hEE, 10'd3, 64'hEE);
        run_instr(3'd0, 11'd4, 128'h0, 0, 1'b0, e);
        check("mask_bytes", wb_data, 128'h00EE00EE);
        vm = 1'b1; v0 = 128'd0;
`endif

        // Reset in COLLECT after three beats
        @(posedge clk); #1;
        start = 1'b1; vsew = 3'd0; vl = 11'd16; old_vd = 128'd7;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            start = 1'b0; lane_valid = 2'b01; lane_index = 20'(b); lane_data = 128'(b + 1);
        end
        @(posedge clk); #1;
        lane_valid = 2'b00;
        @(negedge clk);
        check("pre_reset_cnt", 128'(elem_cnt), 128'd3);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        check("midrst_wb_valid", 128'(wb_valid), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_elem_cnt", 128'(elem_cnt), 128'd0);
        resetn = 1'b1;

        // Randomized instructions
        for (int t = 0; t < 40; t++) begin
            logic [2:0] vs;
            logic [10:0] vlv;
            int hold;
            vs   = 3'($urandom_range(0, 4));
            sew  = (vs > 3'd3) ? 64 : (8 << vs);
            maxe = VLEN / sew;
            vlv  = 11'($urandom_range(0, maxe + 2));
            nb   = $urandom_range(0, 6);
`ifdef RVV_WB_MASK_EN
            vm = 1'($urandom_range(0, 1));
            v0 = {$urandom, $urandom, $urandom, $urandom};
`endif
            for (int b = 0; b < nb; b++)
                push_beat(2'($urandom_range(0, 3)),
                          10'($urandom_range(0, maxe)), {$urandom, $urandom},
                          10'($urandom_range(0, maxe)), {$urandom, $urandom});
            hold = $urandom_range(0, 3);
            run_instr(vs, vlv, {$urandom, $urandom, $urandom, $urandom}, hold, hold >= 2, e);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 128'(sb_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rvv_wb_collector.md
Name: rvv_wb_collector

Overview:
Downstream stage of the multi-lane vector ALU wrapper. It captures per-lane element results (data, element index, lane-valid) beat by beat and merges them into a VLEN-bit destination buffer pre-loaded with the old vd value. When the ALU signals done, it presents the assembled vector to the register-file write port through a valid/ready handshake.

Parameters:
VLEN, 128, vector register width in bits (multiple of 64, max 1024)
NB_LANES, 1, log2 of lane count; lane count L = 1<<NB_LANES (1..8)

Ports:
clk  in  1  clock
resetn  in  1  reset; synchronous, active-low
start  in  1  one-cycle pulse: new instruction, load old_vd and latch vsew/vl
vsew  in  3  element width code; SEW = 8<<vsew; only 0..3 legal
vl  in  11  active vector length in elements
old_vd  in  VLEN  current destination register contents
lane_valid  in  L  per-lane beat valid; lane k uses slice k
lane_data  in  64*L  lane k element in bits [64k+SEW-1:64k]; upper bits ignored
lane_index  in  10*L  lane k element index in bits [10k+9:10k]
alu_done  in  1  last beat is presented this cycle or earlier
wb_ready  in  1  register file accepts wb_data
wb_valid  out  1  assembled vector available
wb_data  out  VLEN  assembled vector
busy  out  1  state != IDLE
elem_cnt  out  11  number of elements written since start
err  out  1  sticky: illegal vsew, or index >= VLEN/SEW on a valid beat

Behaviour:
- Reset: state=IDLE; buffer, wb_data, elem_cnt = 0; wb_valid, busy, err = 0.
- FSM states: IDLE, COLLECT, HOLD.
  - IDLE -> COLLECT on start. On start: buffer <= old_vd; sew_q <= vsew; vl_q <= vl; elem_cnt <= 0; err <= 0.
  - COLLECT: each cycle, for every lane k with lane_valid[k]=1 and index i:
    - If i < min(vl_q, VLEN/SEW), write bits [i*SEW +: SEW] of buffer and add 1 to elem_cnt.
    - If i >= VLEN/SEW, set err and drop the write.
    - If vl_q <= i < VLEN/SEW, drop silently (tail undisturbed).
  - COLLECT -> HOLD on alu_done. Beats present in the same cycle are merged first.
  - HOLD: wb_valid=1, wb_data=buffer. wb_data stays stable while wb_valid=1 and wb_ready=0.
  - HOLD -> IDLE on wb_ready.
- Latency: wb_valid rises the cycle after alu_done is sampled. Minimum start-to-wb_valid is 2 cycles (start, then alu_done in the next cycle).
- wb_data holds its last value while IDLE.
- Same index from two lanes in one cycle: the higher lane number wins; elem_cnt counts both writes.
- start outside IDLE is ignored. alu_done in IDLE is ignored.
- lane_valid in HOLD or IDLE is ignored; no buffer change.
- Illegal vsew (>3) at start: err=1. The block then treats the instruction as SEW=64 and still completes the handshake.
- vl=0: no writes; wb_data=old_vd after alu_done.
- resetn low mid-operation returns to the reset state next edge. Any pending wb_valid is dropped.
- elem_cnt saturates at 2047.

Optional Feature:
RVV_WB_MASK_EN: adds ports vm (in, 1) and v0 (in, VLEN).
- v0 is latched at start.
- With the macro, when vm=0, an element i with v0_q[i]=0 is not written (mask undisturbed) and is not counted.
- Without the macro the ports do not exist and every in-range element is written.

Decomposition:
- Package rvv_wb_pkg holds:
  - state encoding constants (IDLE=2'd0, COLLECT=2'd1, HOLD=2'd2);
  - SEW codes (SEW8=3'd0 .. SEW64=3'd3);
  - a function sew_bits(vsew) returning 8<<vsew;
  - a function max_elems(VLEN, vsew).
- One sub-module, rvv_wb_lane_merge, instantiated once per lane, combinational:
  - inputs: index, data, sew_q, vl_q, valid;
  - outputs: a VLEN-bit write-enable mask, a VLEN-bit positioned data vector, in_range, out_of_bounds.
- The top level ORs the lane masks in priority order, updates the buffer and runs the FSM.

Test Plan:
- VLEN=128, NB_LANES=1, vsew=0, vl=16, old_vd=all 0xFF; indices 0..15 in pairs (lane0 even, lane1 odd), data=index; alu_done on the last pair -> wb_data bytes = 0x00..0x0F, elem_cnt=16, wb_valid one cycle after alu_done.
- vsew=2, vl=3, old_vd=0xAAAA... ; write indices 0,1,2 with 0x11111111, 0x22222222, 0x33333333 -> word3 stays 0xAAAAAAAA, elem_cnt=3, err=0.
- vsew=3, lane_index=2 (>= 128/64) -> err=1, buffer unchanged. Both lanes write index 0 (0x1 on lane0, 0x2 on lane1) -> element0=0x2.
- Hold wb_ready=0 for 5 cycles after wb_valid -> wb_valid and wb_data stable for all 5 cycles. A start pulse during that window is ignored; wb_ready=1 -> IDLE next cycle.
- Assert resetn=0 in COLLECT after 3 beats -> next cycle wb_valid=0, busy=0, elem_cnt=0.
- RVV_WB_MASK_EN defined, vm=0, v0=0x5, vsew=0, vl=4, old_vd=0, write 0xEE to indices 0..3 -> bytes 0,2 = 0xEE, bytes 1,3 = 0x00, elem_cnt=2.
